issue_select: RTL and testbench

ISSUE_SELECT -- requirements
Module: issue_select

---
 rtl/issue_select_pkg.sv | 86 ++++++++
 rtl/issue_select_pick.sv | 39 +++
 rtl/issue_select.sv | 149 ++++++++++++++
 tb/tb_issue_select.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_select_pkg.sv
// rtl/issue_select_pkg.sv - shared types, sizes and payload helpers for the issue selector
package issue_select_pkg;

  localparam int ISSUE_WIDTH_DEFAULT  = 2;
  localparam int STARVE_LIMIT_DEFAULT = 15;

  localparam int BUF_SIZE     = 8;
  localparam int BUF_SIZE_LOG = 3;
  localparam int TAG_W        = BUF_SIZE_LOG + 1;
  localparam int SPECTAG_W    = 3;
  localparam int DATA_W       = 32;

  typedef logic [TAG_W-1:0]        tag_t;
  typedef logic [SPECTAG_W-1:0]    spectag_t;
  typedef logic [BUF_SIZE_LOG-1:0] buf_idx_t;

  typedef enum logic [1:0] {UNIT_ALU, UNIT_LOAD, UNIT_STORE, UNIT_MUL} unit_t;
  typedef enum logic [1:0] {S_EMPTY, S_NOT_EXECUTED, S_ADDR_GENERATED, S_EXECUTED} e_state_t;
  typedef enum logic {EX_NORMAL, EX_GEN_ADDR} ex_mode_t;

  typedef struct packed {
    e_state_t          e_state;
    tag_t              tag;
    unit_t             unit;
    logic [3:0]        op;
    logic [2:0]        rm;
    spectag_t          specific_speculative_tag;
    logic              j_rdy;
    logic              k_rdy;
    logic              a_rdy;
    logic [1:0]        number_of_early_store_ops;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] pc;
  } entry_t;

  typedef struct packed {
    logic              is_valid;
    ex_mode_t          mode;
    unit_t             unit;
    logic [3:0]        op;
    logic [2:0]        rm;
    tag_t              tag;
    spectag_t          speculative_tag;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] pc;
  } ex_content_t;

  // An entry may issue once its operands are ready, it still needs execution
  // (or address generation), no older store blocks a load, and it is not being killed.
  function automatic logic is_eligible(entry_t e, logic kill_valid, spectag_t kill_spectag);
    return e.j_rdy && e.k_rdy &&
           (e.e_state == S_NOT_EXECUTED || e.e_state == S_ADDR_GENERATED) &&
           (e.unit != UNIT_LOAD || e.number_of_early_store_ops == 2'd0) &&
           !(kill_valid && e.specific_speculative_tag == kill_spectag);
  endfunction

  // Without a ready address the entry issues as an ALU address-generation op
  // that carries the address operand in the Vk slot.
  function automatic ex_content_t build_payload(entry_t e, logic flooded);
    ex_content_t c;
    c.is_valid        = 1'b1;
    c.rm              = e.rm;
    c.speculative_tag = e.specific_speculative_tag;
    c.vj              = e.vj;
    c.a               = e.a;
    c.pc              = e.pc;
    c.tag             = flooded ? {1'b1, e.tag[BUF_SIZE_LOG-1:0]} : e.tag;
    if (e.a_rdy) begin
      c.mode = EX_NORMAL;
      c.unit = e.unit;
      c.op   = e.op;
      c.vk   = e.vk;
    end else begin
      c.mode = EX_GEN_ADDR;
      c.unit = UNIT_ALU;
      c.op   = 4'd0;
      c.vk   = e.a;
    end
    return c;
  endfunction

endpackage

// File: rtl/issue_select_pick.sv
// rtl/issue_select_pick.sv - orders eligible entries by descending tag, lowest index on ties
module issue_pick
  import issue_select_pkg::*;
#(
  parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEFAULT
) (
  input  logic [BUF_SIZE-1:0]             eligible,
  input  tag_t [BUF_SIZE-1:0]             tags,
  output buf_idx_t [ISSUE_WIDTH-1:0]      pick_idx,
  output logic [ISSUE_WIDTH-1:0]          pick_valid
);

  // Repeated max-search: each round takes the highest remaining tag and removes it.
  always_comb begin
    logic [BUF_SIZE-1:0] remaining;
    tag_t                best_tag;
    buf_idx_t            best_idx;
    logic                found;
    remaining  = eligible;
    pick_idx   = '0;
    pick_valid = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      found    = 1'b0;
      best_tag = '0;
      best_idx = '0;
      for (int i = 0; i < BUF_SIZE; i++) begin
        if (remaining[i] && (!found || tags[i] > best_tag)) begin
          found    = 1'b1;
          best_tag = tags[i];
          best_idx = buf_idx_t'(i);
        end
      end
      pick_idx[p]   = best_idx;
      pick_valid[p] = found;
      if (found) remaining[best_idx] = 1'b0;
    end
  end

endmodule

// File: rtl/issue_select.sv
// rtl/issue_select.sv - issue port selector; optional starvation guard via ISSUE_STARVE_GUARD_EN
module issue_select
  import issue_select_pkg::*;
#(
  parameter int ISSUE_WIDTH  = ISSUE_WIDTH_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           kill_valid,
  input  spectag_t                       kill_spectag,
  input  logic                           is_tag_flooded,
  input  entry_t [BUF_SIZE-1:0]          entries,
  input  logic [ISSUE_WIDTH-1:0]         out_ready,
  output ex_content_t [ISSUE_WIDTH-1:0]  ex_contents,
  output logic [BUF_SIZE-1:0]            grant
);

  ex_content_t [ISSUE_WIDTH-1:0] ex_q;
  ex_content_t [ISSUE_WIDTH-1:0] ex_next;
  logic [BUF_SIZE-1:0]           eligible;
  tag_t [BUF_SIZE-1:0]           tags;
  logic [BUF_SIZE-1:0]           pick_mask;
  logic [BUF_SIZE-1:0]           cap_grant;
  logic [ISSUE_WIDTH-1:0]        free;
  buf_idx_t [ISSUE_WIDTH-1:0]    pick_idx;
  logic [ISSUE_WIDTH-1:0]        pick_valid;
  logic                          starve_fire;
  buf_idx_t                      starve_idx;

  // Per-entry eligibility and tag extraction.
  always_comb begin
    eligible = '0;
    tags     = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      eligible[i] = is_eligible(entries[i], kill_valid, kill_spectag);
      tags[i]     = entries[i].tag;
    end
  end

  // A port can accept a new issue when empty or when its consumer takes the current one.
  always_comb begin
    free = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      free[p] = !ex_q[p].is_valid || out_ready[p];
    end
  end

`ifdef ISSUE_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  logic       starve_any;
  tag_t       low_tag;

  // Lowest-tag eligible entry, lower index on ties; this is the one a starved cycle rescues.
  always_comb begin
    starve_any = 1'b0;
    starve_idx = '0;
    low_tag    = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (eligible[i] && (!starve_any || tags[i] < low_tag)) begin
        starve_any = 1'b1;
        starve_idx = buf_idx_t'(i);
        low_tag    = tags[i];
      end
    end
  end

  assign starve_fire = (starve_cnt == 4'(STARVE_LIMIT)) && starve_any && (|free) && !flush;

  // The rescued entry is withheld from the normal ordering so it is not issued twice.
  always_comb begin
    pick_mask = eligible;
    if (starve_fire) pick_mask[starve_idx] = 1'b0;
  end

  // Counts consecutive cycles in which some eligible entry was left behind.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      starve_cnt <= 4'd0;
    end else if (starve_fire) begin
      starve_cnt <= 4'd0;
    end else if (|(eligible & ~cap_grant)) begin
      if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end
`else
  assign starve_fire = 1'b0;
  assign starve_idx  = '0;
  assign pick_mask   = eligible;
`endif

  issue_pick #(
    .ISSUE_WIDTH (ISSUE_WIDTH)
  ) u_pick (
    .eligible   (pick_mask),
    .tags       (tags),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // Hand ordered picks to free ports in port order; held ports keep payload unless killed.
  always_comb begin
    int   k;
    logic starve_used;
    ex_next     = ex_q;
    cap_grant   = '0;
    k           = 0;
    starve_used = 1'b0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      if (free[p]) begin
        if (starve_fire && !starve_used) begin
          ex_next[p]            = build_payload(entries[starve_idx], is_tag_flooded);
          cap_grant[starve_idx] = 1'b1;
          starve_used           = 1'b1;
        end else if (k < ISSUE_WIDTH && pick_valid[k]) begin
          ex_next[p]             = build_payload(entries[pick_idx[k]], is_tag_flooded);
          cap_grant[pick_idx[k]] = 1'b1;
          k                      = k + 1;
        end else begin
          ex_next[p].is_valid = 1'b0;
        end
      end else if (kill_valid && ex_q[p].speculative_tag == kill_spectag) begin
        ex_next[p].is_valid = 1'b0;
      end
    end
    if (flush) begin
      cap_grant = '0;
      for (int p = 0; p < ISSUE_WIDTH; p++) begin
        ex_next[p].is_valid = 1'b0;
      end
    end
  end

  // Issue payload register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_next;
    end
  end

  assign ex_contents = ex_q;
  assign grant       = reset ? '0 : cap_grant;

endmodule

// File: tb/tb_issue_select.sv
// tb/tb_issue_select.sv - self-checking bench for issue_select (vector table plus corner sequences)
`timescale 1ns/1ps
module tb_issue_select;
  import issue_select_pkg::*;

  localparam int IW = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic                     kill_valid;
  spectag_t                 kill_spectag;
  logic                     is_tag_flooded;
  entry_t [BUF_SIZE-1:0]    entries;
  logic [IW-1:0]            out_ready;
  ex_content_t [IW-1:0]     ex_contents;
  logic [BUF_SIZE-1:0]      grant;

  always #5 clk = ~clk;

  issue_select #(.ISSUE_WIDTH(IW), .STARVE_LIMIT(15)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .kill_valid     (kill_valid),
    .kill_spectag   (kill_spectag),
    .is_tag_flooded (is_tag_flooded),
    .entries        (entries),
    .out_ready      (out_ready),
    .ex_contents    (ex_contents),
    .grant          (grant)
  );

`ifdef ISSUE_STARVE_GUARD_EN
  logic                 sg_out_ready;
  ex_content_t [0:0]    sg_ex;
  logic [BUF_SIZE-1:0]  sg_grant;

  issue_select #(.ISSUE_WIDTH(1), .STARVE_LIMIT(15)) u_dut_sg (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .kill_valid     (kill_valid),
    .kill_spectag   (kill_spectag),
    .is_tag_flooded (is_tag_flooded),
    .entries        (entries),
    .out_ready      (sg_out_ready),
    .ex_contents    (sg_ex),
    .grant          (sg_grant)
  );
`endif

  typedef struct {
    string               name;
    logic [3:0][2:0]     kind;
    tag_t [3:0]          tag;
    logic [BUF_SIZE-1:0] exp_grant;
    logic [1:0]          exp_v;
    tag_t                exp_t0;
    tag_t                exp_t1;
  } vec_t;

  typedef struct {
    string               name;
    logic [BUF_SIZE-1:0] grant;
    logic [1:0]          v;
    tag_t                t0;
    tag_t                t1;
  } exp_t;

  vec_t  vecs [9];
  exp_t  sb [$];
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // kind: 0 empty, 1 eligible, 2 J not ready, 3 load behind stores, 4 killed spectag,
  // 5 already executed, 6 eligible addr-generated, 7 eligible load without stores
  function automatic entry_t mk_entry(tag_t tag, logic [2:0] kind, spectag_t spec);
    entry_t e;
    e = '0;
    e.e_state = S_NOT_EXECUTED;
    e.tag     = tag;
    e.unit    = UNIT_MUL;
    e.op      = 4'h5;
    e.rm      = 3'd2;
    e.specific_speculative_tag = spec;
    e.j_rdy   = 1'b1;
    e.k_rdy   = 1'b1;
    e.a_rdy   = 1'b1;
    e.vj      = {28'hA000000, tag};
    e.vk      = {28'hB000000, tag};
    e.a       = {28'hC000000, tag};
    e.pc      = {28'h0000100, tag};
    case (kind)
      3'd0: e.e_state = S_EMPTY;
      3'd2: e.j_rdy = 1'b0;
      3'd3: begin e.unit = UNIT_LOAD; e.number_of_early_store_ops = 2'd1; end
      3'd4: e.specific_speculative_tag = 3'd3;
      3'd5: e.e_state = S_EXECUTED;
      3'd6: e.e_state = S_ADDR_GENERATED;
      3'd7: e.unit = UNIT_LOAD;
      default: ;
    endcase
    return e;
  endfunction

  task automatic clear_entries();
    for (int i = 0; i < BUF_SIZE; i++) entries[i] = mk_entry(4'd0, 3'd0, 3'd0);
  endtask

  // Grant is sampled after the inputs settle, outputs #1 after the capturing edge.
  task automatic step(output logic [BUF_SIZE-1:0] g);
    #1 g = grant;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    logic [BUF_SIZE-1:0] g;
    @(negedge clk);
    clear_entries();
    flush = 1'b1;
    step(g);
    flush = 1'b0;
  endtask

  logic [BUF_SIZE-1:0] g;
  exp_t                e;
  int                  seen;

  initial begin
    vecs[0] = '{"two_tags",   {3'd0,3'd0,3'd1,3'd1}, {4'd0,4'd0,4'd9,4'd5},   8'b0000_0011, 2'b11, 4'd9,  4'd5};
    vecs[1] = '{"none",       {3'd0,3'd0,3'd0,3'd0}, {4'd7,4'd6,4'd5,4'd4},   8'b0000_0000, 2'b00, 4'd0,  4'd0};
    vecs[2] = '{"three",      {3'd0,3'd1,3'd1,3'd1}, {4'd0,4'd4,4'd7,4'd2},   8'b0000_0110, 2'b11, 4'd7,  4'd4};
    vecs[3] = '{"tie",        {3'd1,3'd1,3'd0,3'd1}, {4'd6,4'd6,4'd0,4'd6},   8'b0000_0101, 2'b11, 4'd6,  4'd6};
    vecs[4] = '{"j_notrdy",   {3'd0,3'd0,3'd1,3'd2}, {4'd0,4'd0,4'd3,4'd12},  8'b0000_0010, 2'b01, 4'd3,  4'd0};
    vecs[5] = '{"ld_stexec",  {3'd1,3'd1,3'd5,3'd3}, {4'd2,4'd1,4'd8,4'd10},  8'b0000_1100, 2'b11, 4'd2,  4'd1};
    vecs[6] = '{"killed",     {3'd0,3'd0,3'd1,3'd4}, {4'd0,4'd0,4'd13,4'd14}, 8'b0000_0010, 2'b01, 4'd13, 4'd0};
    vecs[7] = '{"max_tag",    {3'd1,3'd0,3'd0,3'd0}, {4'd15,4'd0,4'd0,4'd0},  8'b0000_1000, 2'b01, 4'd15, 4'd0};
    vecs[8] = '{"addr_load",  {3'd0,3'd2,3'd7,3'd6}, {4'd0,4'd12,4'd11,4'd3}, 8'b0000_0011, 2'b11, 4'd11, 4'd3};

    reset = 1'b1; flush = 1'b0; kill_valid = 1'b0; kill_spectag = '0; is_tag_flooded = 1'b0;
    out_ready = 2'b11;
`ifdef ISSUE_STARVE_GUARD_EN
    sg_out_ready = 1'b1;
`endif
    clear_entries();
    entries[0] = mk_entry(4'd9, 3'd1, 3'd0);
    step(g);
    check("reset_grant", g, 8'h00);
    check("reset_valid", {ex_contents[1].is_valid, ex_contents[0].is_valid}, 2'b00);
    check("reset_vj", ex_contents[0].vj, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      do_flush();
      @(negedge clk);
      kill_valid = 1'b1; kill_spectag = 3'd3; out_ready = 2'b11;
      for (int i = 0; i < BUF_SIZE; i++)
        entries[i] = (i < 4) ? mk_entry(vecs[v].tag[i], vecs[v].kind[i], 3'd0) : mk_entry(4'd0, 3'd0, 3'd0);
      sb.push_back('{vecs[v].name, vecs[v].exp_grant, vecs[v].exp_v, vecs[v].exp_t0, vecs[v].exp_t1});
      step(g);
      e = sb.pop_front();
      check({e.name, "_grant"}, g, e.grant);
      check({e.name, "_valid"}, {ex_contents[1].is_valid, ex_contents[0].is_valid}, e.v);
      if (e.v[0]) check({e.name, "_tag0"}, ex_contents[0].tag, e.t0);
      if (e.v[1]) check({e.name, "_tag1"}, ex_contents[1].tag, e.t1);
    end
    kill_valid = 1'b0;

    // held port keeps payload; new entry goes to the other port
    do_flush();
    @(negedge clk);
    out_ready = 2'b00; entries[0] = mk_entry(4'd4, 3'd1, 3'd0);
    step(g);
    check("hold_first_grant", g, 8'b01);
    @(negedge clk);
    clear_entries(); entries[1] = mk_entry(4'd6, 3'd1, 3'd0);
    step(g);
    check("hold_grant", g, 8'b10);
    check("hold_p0_tag", ex_contents[0].tag, 4'd4);
    check("hold_p0_vj", ex_contents[0].vj, 32'hA0000004);
    check("hold_p1_tag", ex_contents[1].tag, 4'd6);
    check("hold_valid", {ex_contents[1].is_valid, ex_contents[0].is_valid}, 2'b11);
    @(negedge clk);
    clear_entries(); out_ready = 2'b01;
    step(g);
    check("drain_grant", g, 8'h00);
    check("drain_valid", {ex_contents[1].is_valid, ex_contents[0].is_valid}, 2'b10);

    // kill of a held port by speculative tag
    do_flush();
    @(negedge clk);
    out_ready = 2'b11;
    entries[0] = mk_entry(4'd5, 3'd1, 3'd2);
    entries[1] = mk_entry(4'd3, 3'd1, 3'd1);
    step(g);
    check("kill_setup_spec", ex_contents[0].speculative_tag, 3'd2);
    @(negedge clk);
    clear_entries(); out_ready = 2'b00; kill_valid = 1'b1; kill_spectag = 3'd2;
    step(g);
    check("kill_valid", {ex_contents[1].is_valid, ex_contents[0].is_valid}, 2'b10);
    check("kill_keep_tag", ex_contents[1].tag, 4'd3);
    kill_valid = 1'b0;

    // tag flooding and address-generation payload, then a normal payload
    do_flush();
    @(negedge clk);
    out_ready = 2'b11; is_tag_flooded = 1'b1;
    entries[2] = mk_entry(4'b0011, 3'd1, 3'd0);
    entries[2].a_rdy = 1'b0;
    step(g);
    check("flood_grant", g, 8'b100);
    check("flood_tag", ex_contents[0].tag, 4'b1011);
    check("flood_mode", ex_contents[0].mode, EX_GEN_ADDR);
    check("flood_unit", ex_contents[0].unit, UNIT_ALU);
    check("flood_op", ex_contents[0].op, 4'd0);
    check("flood_vk", ex_contents[0].vk, 32'hC0000003);
    check("flood_pc", ex_contents[0].pc, 32'h00001003);
    @(negedge clk);
    is_tag_flooded = 1'b0;
    entries[2] = mk_entry(4'd7, 3'd1, 3'd0);
    step(g);
    check("normal_tag", ex_contents[0].tag, 4'd7);
    check("normal_mode", ex_contents[0].mode, EX_NORMAL);
    check("normal_unit", ex_contents[0].unit, UNIT_MUL);
    check("normal_op_rm", {ex_contents[0].op, ex_contents[0].rm}, {4'h5, 3'd2});
    check("normal_vk", ex_contents[0].vk, 32'hB0000007);

    // flush, then reset (with flush) mid-stream
    do_flush();
    @(negedge clk);
    entries[0] = mk_entry(4'd9, 3'd1, 3'd0);
    entries[1] = mk_entry(4'd2, 3'd1, 3'd0);
    step(g);
    check("pre_flush_valid", {ex_contents[1].is_valid, ex_contents[0].is_valid}, 2'b11);
    @(negedge clk);
    flush = 1'b1;
    step(g);
    check("flush_grant", g, 8'h00);
    check("flush_valid", {ex_contents[1].is_valid, ex_contents[0].is_valid}, 2'b00);
    @(negedge clk);
    flush = 1'b0;
    step(g);
    check("refill_tag0", ex_contents[0].tag, 4'd9);
    @(negedge clk);
    reset = 1'b1; flush = 1'b1;
    step(g);
    check("reset_mid_grant", g, 8'h00);
    check("reset_mid_valid", {ex_contents[1].is_valid, ex_contents[0].is_valid}, 2'b00);
    check("reset_mid_tag", ex_contents[0].tag, 4'd0);
    @(negedge clk);
    reset = 1'b0; flush = 1'b0;

`ifndef ISSUE_STARVE_GUARD_EN
    // without the guard the lowest tag never wins against two higher ones
    do_flush();
    @(negedge clk);
    out_ready = 2'b11;
    entries[0] = mk_entry(4'd1, 3'd1, 3'd0);
    entries[1] = mk_entry(4'd8, 3'd1, 3'd0);
    entries[2] = mk_entry(4'd9, 3'd1, 3'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step(g);
      if (g[0]) seen++;
    end
    check("no_guard_low_grants", seen, 0);
    check("no_guard_grant", g, 8'b110);
`else
    // with the guard the low tag is rescued once the counter saturates
    do_flush();
    @(negedge clk);
    sg_out_ready = 1'b1;
    entries[0] = mk_entry(4'd1, 3'd1, 3'd0);
    entries[1] = mk_entry(4'd8, 3'd1, 3'd0);
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      #1 if (sg_grant[0] && seen == 0) seen = c;
      @(posedge clk);
      #1;
      if (c == 16) check("starve_tag", sg_ex[0].tag, 4'd1);
    end
    check("starve_cycle", seen, 16);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
